f1_reaction_monitor: RTL

Consumer of the F1 start-light pattern. It watches the 8-bit light bus driven by the F1 light sequencer and detects "lights out", the 0xFF to 0x00 transition. It then counts millisecond ticks until the driver's button press and reports the reaction time. Presses made before lights out are flagged as false starts. It sits beside the sequencer in the F1 top level and shares the clktick-derived tick with it, or uses its own 1 ms tick.

---
 rtl/f1_reaction_monitor.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/f1_reaction_monitor.sv
// f1_reaction_monitor: watches the F1 start-light bus for lights out (0xFF -> 0x00),
// then counts 1 ms ticks until the driver presses the button. A press made before
// lights out is flagged as a false start.
module f1_reaction_monitor #(
  parameter int unsigned TIMEOUT_MS = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [7:0]  light_in,
  input  logic        button,
  output logic [15:0] reaction_ms,
  output logic        valid,
  output logic        false_start,
  output logic        timeout,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMING = 3'd1,
    S_ARMED  = 3'd2,
    S_TIMING = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_MS);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        w_press;
  logic [15:0] r_counter;
  logic [15:0] w_counter_next;
  logic [15:0] w_cnt_inc;
  logic [15:0] r_reaction;
  logic [15:0] w_reaction_next;
  logic        r_valid;
  logic        w_valid_next;
  logic        r_false_start;
  logic        w_false_start_next;
  logic        r_timeout;
  logic        w_timeout_next;

  // Rising edge of the synchronised button; a held button yields one press.
  assign w_press = r_sync2 & ~r_sync3;

  // Count including a tick that lands in the same cycle. The FSM leaves TIMING
  // when this reaches LP_TIMEOUT, so the 16-bit counter can never wrap.
  assign w_cnt_inc = r_counter + 16'(tick);

  // Two-flop synchroniser plus a third stage for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_counter     <= 16'd0;
      r_reaction    <= 16'd0;
      r_valid       <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_counter     <= w_counter_next;
      r_reaction    <= w_reaction_next;
      r_valid       <= w_valid_next;
      r_false_start <= w_false_start_next;
      r_timeout     <= w_timeout_next;
    end
  end

  // Next-state and next-output decisions; at most one transition per clock.
  always_comb begin
    w_state_next       = r_state;
    w_counter_next     = r_counter;
    w_reaction_next    = r_reaction;
    w_valid_next       = 1'b0;
    w_false_start_next = r_false_start;
    w_timeout_next     = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (light_in != 8'h00) begin
          w_state_next       = S_ARMING;
          w_false_start_next = 1'b0;
          w_timeout_next     = 1'b0;
        end
      end
      S_ARMING: begin
        if (w_press) begin
          w_state_next       = S_FAULT;
          w_false_start_next = 1'b1;
        end else if (light_in == 8'hFF) begin
          w_state_next = S_ARMED;
        end else if (light_in == 8'h00) begin
          w_state_next = S_IDLE;
        end
      end
      S_ARMED: begin
        // A press coinciding with lights out is still a jump start.
        if (w_press) begin
          w_state_next       = S_FAULT;
          w_false_start_next = 1'b1;
        end else if (light_in == 8'h00) begin
          w_state_next   = S_TIMING;
          w_counter_next = 16'd0;
        end
      end
      S_TIMING: begin
        w_counter_next = w_cnt_inc;
        // Press wins over timeout; both then capture the same value.
        if (w_press) begin
          w_reaction_next = w_cnt_inc;
          w_valid_next    = 1'b1;
          w_state_next    = S_DONE;
        end else if (w_cnt_inc == LP_TIMEOUT) begin
          w_reaction_next = LP_TIMEOUT;
          w_timeout_next  = 1'b1;
          w_valid_next    = 1'b1;
          w_state_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (light_in != 8'h00) begin
          w_state_next       = S_ARMING;
          w_false_start_next = 1'b0;
          w_timeout_next     = 1'b0;
        end
      end
      S_FAULT: begin
        if (light_in == 8'h00) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign reaction_ms = r_reaction;
  assign valid       = r_valid;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;
  assign state       = r_state;

endmodule
